// File: rtl/cache_miss_ctrl.sv
// rtl/cache_miss_ctrl.sv - miss controller for a direct-mapped write-back cache
// Hits complete in IDLE; misses write back a dirty victim, refill four words, then replay.
module cache_miss_ctrl #(
    parameter  int MEM_LAT = 2,
    parameter  int IDX_W   = 8,
    localparam int TAG_W   = 13 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_rd,
    input  logic             req_wr,
    input  logic [15:0]      req_addr,
    input  logic [15:0]      req_data,
    output logic             done,
    output logic             cache_hit,
    output logic [15:0]      data_out,
    output logic             stall_out,
    output logic             err,
    output logic             c_enable,
    output logic [IDX_W-1:0] c_index,
    output logic [2:0]       c_offset,
    output logic             c_comp,
    output logic             c_write,
    output logic [TAG_W-1:0] c_tag_in,
    output logic [15:0]      c_data_in,
    output logic             c_valid_in,
    input  logic             c_hit,
    input  logic             c_dirty,
    input  logic             c_valid,
    input  logic [TAG_W-1:0] c_tag_out,
    input  logic [15:0]      c_data_out,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_data_wr,
    output logic             mem_wr,
    output logic             mem_rd,
    input  logic             mem_stall,
    input  logic [15:0]      mem_data_rd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_FILL,
        S_FILL_WAIT,
        S_FINISH
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [1:0]         k;
    logic [1:0]         ret_cnt;
    logic [MEM_LAT-1:0] pipe_v;
    logic [1:0]         pipe_k [MEM_LAT];
    logic [15:1]        addr_r;
    logic [15:0]        data_r;
    logic               wr_r;
    logic [TAG_W-1:0]   victim_tag;

    logic               req_any;
    logic               req_err;
    logic               req_ok;
    logic               lookup_hit;
    logic               push;
    logic               service;
    logic [1:0]         head_k;
    logic [TAG_W-1:0]   tag_r;
    logic [IDX_W-1:0]   idx_r;
    logic [1:0]         wsel_r;

    // Request decode is gated by rst so every output is 0 while reset is held.
    assign req_any    = !rst && (state == S_IDLE) && (req_rd || req_wr);
    assign req_err    = req_any && ((req_rd && req_wr) || req_addr[0]);
    assign req_ok     = req_any && !req_err;
    assign lookup_hit = c_hit && c_valid;

    assign tag_r  = addr_r[15:3+IDX_W];
    assign idx_r  = addr_r[2+IDX_W:3];
    assign wsel_r = addr_r[2:1];

    assign push    = (state == S_FILL) && !mem_stall;
    assign head_k  = pipe_k[MEM_LAT-1];
    assign service = pipe_v[MEM_LAT-1] && ((state == S_FILL) || (state == S_FILL_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (req_ok && !lookup_hit) begin
                    state_nx = (c_valid && c_dirty) ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                if (!mem_stall && (k == 2'd3)) state_nx = S_FILL;
            end
            S_FILL: begin
                if (!mem_stall && (k == 2'd3)) state_nx = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                if (service && (ret_cnt == 2'd3)) state_nx = S_FINISH;
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Return pipeline shifts every cycle; only accepted reads enter it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k          <= '0;
            ret_cnt    <= '0;
            pipe_v     <= '0;
            for (int i = 0; i < MEM_LAT; i++) pipe_k[i] <= '0;
            addr_r     <= '0;
            data_r     <= '0;
            wr_r       <= 1'b0;
            victim_tag <= '0;
        end else begin
            for (int i = MEM_LAT - 1; i > 0; i--) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_k[i] <= pipe_k[i-1];
            end
            pipe_v[0] <= push;
            pipe_k[0] <= k;

            if (state == S_IDLE) begin
                k       <= '0;
                ret_cnt <= '0;
                if (req_ok) begin
                    addr_r <= req_addr[15:1];
                    data_r <= req_data;
                    wr_r   <= req_wr;
                    if (!lookup_hit) victim_tag <= c_tag_out;
                end
            end else begin
                if (((state == S_WB) || (state == S_FILL)) && !mem_stall) k <= k + 2'd1;
                if (service) ret_cnt <= ret_cnt + 2'd1;
            end
        end
    end

    always_comb begin
        done        = 1'b0;
        cache_hit   = 1'b0;
        data_out    = '0;
        stall_out   = (state != S_IDLE);
        err         = 1'b0;
        c_enable    = 1'b0;
        c_index     = '0;
        c_offset    = '0;
        c_comp      = 1'b0;
        c_write     = 1'b0;
        c_tag_in    = '0;
        c_data_in   = '0;
        c_valid_in  = 1'b0;
        mem_addr    = '0;
        mem_data_wr = '0;
        mem_wr      = 1'b0;
        mem_rd      = 1'b0;
        case (state)
            S_IDLE: begin
                err = req_err;
                if (req_ok) begin
                    c_enable  = 1'b1;
                    c_comp    = 1'b1;
                    c_write   = req_wr;
                    c_index   = req_addr[2+IDX_W:3];
                    c_offset  = {req_addr[2:1], 1'b0};
                    c_tag_in  = req_addr[15:3+IDX_W];
                    c_data_in = req_data;
                    if (lookup_hit) begin
                        done      = 1'b1;
                        cache_hit = 1'b1;
                        if (req_rd) data_out = c_data_out;
                    end
                end
            end
            S_WB: begin
                c_enable    = 1'b1;
                c_index     = idx_r;
                c_offset    = {k, 1'b0};
                mem_wr      = 1'b1;
                mem_addr    = {victim_tag, idx_r, k, 1'b0};
                mem_data_wr = c_data_out;
            end
            S_FILL: begin
                mem_rd   = 1'b1;
                mem_addr = {tag_r, idx_r, k, 1'b0};
            end
            S_FINISH: begin
                c_enable  = 1'b1;
                c_comp    = 1'b1;
                c_write   = wr_r;
                c_index   = idx_r;
                c_offset  = {wsel_r, 1'b0};
                c_tag_in  = tag_r;
                c_data_in = data_r;
                done      = 1'b1;
                if (!wr_r) data_out = c_data_out;
            end
            default: ;
        endcase
        // The line only becomes valid with its last word, so an aborted fill leaves it invalid.
        if (service) begin
            c_enable   = 1'b1;
            c_write    = 1'b1;
            c_index    = idx_r;
            c_offset   = {head_k, 1'b0};
            c_tag_in   = tag_r;
            c_data_in  = mem_data_rd;
            c_valid_in = (ret_cnt == 2'd3);
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb/tb_cache_miss_ctrl.sv - directed bench for cache_miss_ctrl with cache-array and memory models
module tb_cache_miss_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rd, req_wr;
    logic [15:0] req_addr, req_data;
    logic        done, cache_hit, stall_out, err;
    logic [15:0] data_out;
    logic        c_enable, c_comp, c_write, c_valid_in;
    logic [7:0]  c_index;
    logic [2:0]  c_offset;
    logic [4:0]  c_tag_in;
    logic [15:0] c_data_in;
    logic        c_hit, c_dirty, c_valid;
    logic [4:0]  c_tag_out;
    logic [15:0] c_data_out;
    logic [15:0] mem_addr, mem_data_wr, mem_data_rd;
    logic        mem_wr, mem_rd, mem_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_miss_ctrl #(.MEM_LAT(2), .IDX_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
        .done(done), .cache_hit(cache_hit), .data_out(data_out),
        .stall_out(stall_out), .err(err),
        .c_enable(c_enable), .c_index(c_index), .c_offset(c_offset), .c_comp(c_comp),
        .c_write(c_write), .c_tag_in(c_tag_in), .c_data_in(c_data_in), .c_valid_in(c_valid_in),
        .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid), .c_tag_out(c_tag_out),
        .c_data_out(c_data_out),
        .mem_addr(mem_addr), .mem_data_wr(mem_data_wr), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_stall(mem_stall), .mem_data_rd(mem_data_rd)
    );

    // Cache arrays: tag/valid/dirty/data, not cleared by rst
    logic [4:0]  ct   [256];
    logic        cv   [256];
    logic        cd   [256];
    logic [15:0] cdat [256][4];

    initial begin
        for (int i = 0; i < 256; i++) begin
            cv[i] <= 1'b0;
            cd[i] <= 1'b0;
            ct[i] <= '0;
            for (int j = 0; j < 4; j++) cdat[i][j] <= '0;
        end
    end

    always_comb begin
        c_tag_out  = ct[c_index];
        c_valid    = cv[c_index];
        c_dirty    = cd[c_index];
        c_data_out = cdat[c_index][c_offset[2:1]];
        c_hit      = c_enable && c_comp && (ct[c_index] == c_tag_in);
    end

    always @(posedge clk) begin
        if (c_enable && c_write) begin
            if (c_comp) begin
                if (c_hit && c_valid) begin
                    cdat[c_index][c_offset[2:1]] <= c_data_in;
                    cd[c_index] <= 1'b1;
                end
            end else begin
                cdat[c_index][c_offset[2:1]] <= c_data_in;
                ct[c_index] <= c_tag_in;
                cv[c_index] <= c_valid_in;
                cd[c_index] <= 1'b0;
            end
        end
    end

    // Main memory: word = address ^ 0x5A5A initially, read data two cycles after acceptance
    logic [15:0] mm [32768];
    logic        dl_v0 = 1'b0, dl_v1 = 1'b0;
    logic [15:0] dl_a0 = '0, dl_a1 = '0;

    initial begin
        for (int i = 0; i < 32768; i++) mm[i] <= 16'(i * 2) ^ 16'h5A5A;
    end

    always @(posedge clk) begin
        dl_v0 <= mem_rd && !mem_stall;
        dl_a0 <= mem_addr;
        dl_v1 <= dl_v0;
        dl_a1 <= dl_a0;
        if (mem_wr && !mem_stall) mm[mem_addr[15:1]] <= mem_data_wr;
    end

    assign mem_data_rd = dl_v1 ? mm[dl_a1[15:1]] : 16'hDEAD;

    // Bus monitor
    logic [15:0] rd_q [$];
    logic [15:0] wr_a [$];
    logic [15:0] wr_d [$];
    int          n812 = 0;

    always @(negedge clk) begin
        if (mem_rd && !mem_stall) rd_q.push_back(mem_addr);
        if (mem_wr && !mem_stall) begin
            wr_a.push_back(mem_addr);
            wr_d.push_back(mem_data_wr);
        end
        if (mem_rd && (mem_addr == 16'h0812)) n812++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    int rd_base, wr_base, n812_base;

    // One access; lat is the 1-based cycle of done (0 = no done within budget)
    task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] data, input int st_start, input int st_len,
                          output int lat, output logic hit, output logic [15:0] rdata);
        rd_base   = rd_q.size();
        wr_base   = wr_a.size();
        n812_base = n812;
        lat   = 0;
        hit   = 1'b0;
        rdata = '0;
        @(posedge clk);
        #1;
        req_rd   = rd;
        req_wr   = wr;
        req_addr = addr;
        req_data = data;
        for (int c = 1; c <= 100; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
                req_rd = 1'b0;
                req_wr = 1'b0;
            end
            mem_stall = (c >= st_start) && (c < st_start + st_len);
            @(negedge clk);
            if (done) begin
                lat   = c;
                hit   = cache_hit;
                rdata = data_out;
                break;
            end
        end
        mem_stall = 1'b0;
        #1;
    endtask

    int          lat;
    logic        hit;
    logic [15:0] rdata;

    initial begin
        rst       = 1'b1;
        req_rd    = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 16'h0010;
        req_data  = '0;
        mem_stall = 1'b0;

        // Outputs must all be 0 under reset even with a request present
        @(negedge clk);
        check("rst_c_enable", c_enable, 0);
        check("rst_stall", stall_out, 0);
        check("rst_done", done, 0);
        check("rst_mem_rd", mem_rd, 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        req_rd = 1'b0;

        // 1: cold read miss
        do_req(1'b1, 1'b0, 16'h0010, 16'h0, 0, 0, lat, hit, rdata);
        check("s1_latency", lat, 8);
        check("s1_hit", hit, 0);
        check("s1_data", rdata, 16'h5A4A);
        check("s1_rd_count", rd_q.size() - rd_base, 4);
        for (int i = 0; i < 4; i++) check("s1_rd_addr", rd_q[rd_base + i], 16'h0010 + 16'(2 * i));
        check("s1_wr_count", wr_a.size() - wr_base, 0);

        // 2: read hit
        do_req(1'b1, 1'b0, 16'h0012, 16'h0, 0, 0, lat, hit, rdata);
        check("s2_latency", lat, 1);
        check("s2_hit", hit, 1);
        check("s2_data", rdata, 16'h5A48);
        check("s2_mem_traffic", (rd_q.size() - rd_base) + (wr_a.size() - wr_base), 0);

        // 3: write hit then conflicting read forces a write-back
        do_req(1'b0, 1'b1, 16'h0010, 16'hBEEF, 0, 0, lat, hit, rdata);
        check("s3w_latency", lat, 1);
        check("s3w_hit", hit, 1);
        do_req(1'b1, 1'b0, 16'h2010, 16'h0, 0, 0, lat, hit, rdata);
        check("s3_latency", lat, 12);
        check("s3_hit", hit, 0);
        check("s3_data", rdata, 16'h7A4A);
        check("s3_wr_count", wr_a.size() - wr_base, 4);
        for (int i = 0; i < 4; i++) check("s3_wr_addr", wr_a[wr_base + i], 16'h0010 + 16'(2 * i));
        check("s3_wr_data0", wr_d[wr_base], 16'hBEEF);
        check("s3_wr_data1", wr_d[wr_base + 1], 16'h5A48);
        check("s3_rd_addr0", rd_q[rd_base], 16'h2010);
        check("s3_rd_addr3", rd_q[rd_base + 3], 16'h2016);

        // 4: three-cycle stall on the second fill issue
        do_req(1'b1, 1'b0, 16'h0810, 16'h0, 3, 3, lat, hit, rdata);
        check("s4_latency", lat, 11);
        check("s4_hold_0812", n812 - n812_base, 4);
        check("s4_rd_count", rd_q.size() - rd_base, 4);
        check("s4_data", rdata, 16'h524A);

        // 5: illegal requests
        @(posedge clk);
        #1;
        req_rd   = 1'b1;
        req_wr   = 1'b1;
        req_addr = 16'h0010;
        @(negedge clk);
        check("s5a_err", err, 1);
        check("s5a_done", done, 0);
        check("s5a_strobes", {c_enable, mem_rd, mem_wr, stall_out}, 4'b0000);
        @(posedge clk);
        #1;
        req_rd = 1'b0;
        req_wr = 1'b0;
        @(negedge clk);
        check("s5_err_pulse", err, 0);
        @(posedge clk);
        #1;
        req_rd   = 1'b1;
        req_addr = 16'h0011;
        @(negedge clk);
        check("s5b_err", err, 1);
        check("s5b_strobes", {done, c_enable, mem_rd, mem_wr}, 4'b0000);
        @(posedge clk);
        #1;
        req_rd = 1'b0;

        // 6: reset after the second fill return, then the same read refills fully
        @(posedge clk);
        #1;
        req_rd   = 1'b1;
        req_addr = 16'h1010;
        for (int c = 2; c <= 5; c++) begin
            @(posedge clk);
            #1;
            req_rd = 1'b0;
        end
        @(negedge clk);
        check("s6_mid_fill_stall", stall_out, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("s6_rst_outputs", {stall_out, c_enable, mem_rd, done}, 4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("s6_late_return_ignored", {c_enable, c_write, stall_out}, 3'b000);
        do_req(1'b1, 1'b0, 16'h1010, 16'h0, 0, 0, lat, hit, rdata);
        check("s6_latency", lat, 8);
        check("s6_hit", hit, 0);
        check("s6_data", rdata, 16'h4A4A);
        check("s6_rd_count", rd_q.size() - rd_base, 4);

        // 7: written-back word returns from memory on refill
        do_req(1'b1, 1'b0, 16'h0010, 16'h0, 0, 0, lat, hit, rdata);
        check("s7_latency", lat, 8);
        check("s7_data", rdata, 16'hBEEF);
        check("s7_wr_count", wr_a.size() - wr_base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
